// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, fetch state encoding and the supported-instruction check shared with the control unit.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_ADDU  = 6'd33;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_HOLD = 2'd1, S_HALT = 2'd2} fetch_state_t;
  function automatic logic is_legal(input logic [31:0] w);
    return (w[31:26] == OP_RTYPE) ? (w[5:0] inside {FN_MULT, FN_ADD, FN_ADDU, FN_AND, FN_OR})
                                  : (w[31:26] inside {OP_J, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI});
  endfunction
endpackage

// File: rtl/if_legal_chk.sv
// if_legal_chk: combinational flag telling whether a fetched word belongs to the supported instruction set.
import mips_pkg::*;
module if_legal_chk (
  input  logic [31:0] instr_i,
  output logic        legal_o
);
  assign legal_o = is_legal(instr_i);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, single-outstanding imem fetch and valid/ready hand-off to the control unit.
// Define IF_ILLEGAL_DET_EN to halt (sticky illegal_o) on an unsupported fetched word.
import mips_pkg::*;
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_o,
  output logic [5:0]  opcode_o,
  output logic [5:0]  func_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic        jump_i,
  output logic [31:0] retired_o,
  output logic        illegal_o
);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, retired_q, retired_d, pc_plus4;
  logic illegal_q, illegal_d, legal;
`ifdef IF_ILLEGAL_DET_EN
  if_legal_chk u_chk (.instr_i(imem_rdata), .legal_o(legal));
`else
  assign legal = 1'b1;
`endif
  assign pc_plus4   = pc_q + 32'd4;
  assign imem_req   = !rst && state_q == S_FETCH;
  assign valid_o    = !rst && state_q == S_HOLD;
  assign imem_addr  = pc_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4;
  assign instr_o    = instr_q;
  assign opcode_o   = instr_q[31:26];
  assign func_o     = instr_q[5:0];
  assign retired_o  = retired_q;
  assign illegal_o  = illegal_q;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    if (state_q == S_FETCH && imem_ack) begin
      instr_d   = imem_rdata;
      state_d   = legal ? S_HOLD : S_HALT;
      illegal_d = illegal_q | !legal;
    end
    if (state_q == S_HOLD && ready_i) begin
      retired_d = retired_q + 32'd1;
      pc_d      = jump_i ? {pc_plus4[31:28], instr_q[25:0], 2'b00} : pc_plus4;
      state_d   = S_FETCH;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized fetch traffic against a PC/retire reference model with a scoreboard monitor.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, imem_ack, ready_i, jump_i, imem_req, valid_o, illegal_o;
  logic [31:0] imem_rdata, imem_addr, instr_o, pc_o, pc_plus4_o, retired_o;
  logic [5:0] opcode_o, func_o;
  logic w_ack, w_ready, w_jump, w_req, w_valid, w_illegal;
  logic [31:0] w_rdata, w_addr, w_instr, w_pc, w_pc_plus4, w_retired;
  logic [5:0] w_opcode, w_func;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_o(instr_o), .opcode_o(opcode_o), .func_o(func_o), .pc_o(pc_o),
    .pc_plus4_o(pc_plus4_o), .valid_o(valid_o), .ready_i(ready_i), .jump_i(jump_i),
    .retired_o(retired_o), .illegal_o(illegal_o)
  );
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
    .imem_rdata(w_rdata), .instr_o(w_instr), .opcode_o(w_opcode), .func_o(w_func), .pc_o(w_pc),
    .pc_plus4_o(w_pc_plus4), .valid_o(w_valid), .ready_i(w_ready), .jump_i(w_jump),
    .retired_o(w_retired), .illegal_o(w_illegal)
  );

  typedef struct { logic [31:0] pc; logic [31:0] word; logic [31:0] ret; } exp_t;
  exp_t sb[$];
  exp_t cur;
  bit have = 0;
  int total = 0, bad = 0;
  logic [31:0] m_pc, m_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_legal();
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    logic [31:0] w;
    ops = '{6'd0, 6'd2, 6'd8, 6'd9, 6'd12, 6'd13};
    fns = '{6'd24, 6'd32, 6'd33, 6'd36, 6'd37};
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 5)];
    if (w[31:26] == 6'd0) w[5:0] = fns[$urandom_range(0, 4)];
    return w;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] word, input bit j);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    return j ? {p4[31:28], word[25:0], 2'b00} : p4;
  endfunction

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", 32'(imem_req), 32'd1);
  endtask

  task automatic do_instr(input logic [31:0] word, input int lat, input int stall, input bit j);
    wait_req();
    chk("req_addr", imem_addr, m_pc);
    for (int i = 0; i < lat; i++) begin
      step();
      chk("addr_hold", imem_addr, m_pc);
      chk("valid_wait", 32'(valid_o), 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    sb.push_back('{m_pc, word, m_ret});
    step();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    chk("valid_after_ack", 32'(valid_o), 32'd1);
    for (int i = 0; i < stall; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      jump_i = 1'($urandom_range(0, 1));
      step();
    end
    imem_ack = 1'b0;
    ready_i = 1'b1;
    jump_i = j;
    step();
    ready_i = 1'b0;
    jump_i = 1'($urandom_range(0, 1));
    m_ret = m_ret + 32'd1;
    m_pc = next_pc(m_pc, word, j);
    chk("valid_drop", 32'(valid_o), 32'd0);
    chk("next_req", 32'(imem_req), 32'd1);
    chk("next_addr", imem_addr, m_pc);
  endtask

  task automatic reset_mid();
    wait_req();
    step();
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0020;
    step();
    chk("rst_req_low", 32'(imem_req), 32'd0);
    chk("rst_valid_low", 32'(valid_o), 32'd0);
    step();
    rst = 1'b0;
    imem_ack = 1'b0;
    m_pc = 32'd0;
    m_ret = 32'd0;
    step();
    chk("rst_restart_req", 32'(imem_req), 32'd1);
    chk("rst_restart_addr", imem_addr, 32'd0);
    chk("rst_retired", retired_o, 32'd0);
    chk("rst_no_valid", 32'(valid_o), 32'd0);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) have = 0;
    else if (valid_o) begin
      if (!have) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_valid: got valid_o=1 expected no pending instruction");
        end else begin
          cur = sb.pop_front();
          have = 1;
        end
      end
      if (have) begin
        chk("instr", instr_o, cur.word);
        chk("opcode", 32'(opcode_o), 32'(cur.word[31:26]));
        chk("func", 32'(func_o), 32'(cur.word[5:0]));
        chk("pc", pc_o, cur.pc);
        chk("pc_plus4", pc_plus4_o, cur.pc + 32'd4);
        chk("retired", retired_o, cur.ret);
        chk("no_req_while_valid", 32'(imem_req), 32'd0);
        chk("illegal_low", 32'(illegal_o), 32'd0);
      end
      if (ready_i) have = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; ready_i = 1'b0; jump_i = 1'b0;
    w_ack = 1'b0; w_rdata = '0; w_ready = 1'b0; w_jump = 1'b0;
    m_pc = 32'd0; m_ret = 32'd0;
    step();
    step();
    chk("reset_req", 32'(imem_req), 32'd0);
    chk("reset_valid", 32'(valid_o), 32'd0);
    rst = 1'b0;
    step();
    chk("init_req", 32'(imem_req), 32'd1);
    chk("init_addr", imem_addr, 32'd0);
    chk("init_valid", 32'(valid_o), 32'd0);
    chk("init_retired", retired_o, 32'd0);
    chk("init_illegal", 32'(illegal_o), 32'd0);
    do_instr(32'h0000_0020, 3, 0, 1'b0);
    chk("add_next_addr", imem_addr, 32'd4);
    chk("add_retired", retired_o, 32'd1);
    do_instr(rand_legal(), 1, 5, 1'b0);
    reset_mid();
    do_instr(32'h0800_0010, 0, 0, 1'b1);
    chk("jump_target", imem_addr, 32'h0000_0040);
    reset_mid();
    do_instr(32'h0800_0010, 0, 0, 1'b0);
    chk("no_jump_target", imem_addr, 32'h0000_0004);
    repeat (200) do_instr(rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    chk("wrap_init_addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap_init_req", 32'(w_req), 32'd1);
    w_ack = 1'b1;
    w_rdata = 32'h0000_0020;
    step();
    w_ack = 1'b0;
    chk("wrap_valid", 32'(w_valid), 32'd1);
    chk("wrap_pc_plus4", w_pc_plus4, 32'd0);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    chk("wrap_next_addr", w_addr, 32'd0);
    chk("wrap_retired", w_retired, 32'd1);
    chk("wrap_next_req", 32'(w_req), 32'd1);
`ifdef IF_ILLEGAL_DET_EN
    wait_req();
    imem_ack = 1'b1;
    imem_rdata = 32'h8C00_0000;
    step();
    imem_ack = 1'b0;
    ready_i = 1'b1;
    repeat (4) begin
      chk("halt_illegal", 32'(illegal_o), 32'd1);
      chk("halt_valid", 32'(valid_o), 32'd0);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_pc", pc_o, m_pc);
      chk("halt_instr", instr_o, 32'h8C00_0000);
      step();
    end
    ready_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("halt_exit_illegal", 32'(illegal_o), 32'd0);
    chk("halt_exit_req", 32'(imem_req), 32'd1);
    chk("halt_exit_addr", imem_addr, 32'd0);
`else
    do_instr(32'h8C00_0000, 1, 0, 1'b0);
    chk("lw_no_illegal", 32'(illegal_o), 32'd0);
`endif
    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
